// File: rtl/uart_tx_lite_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_lite_pkg
// Shared definitions for the console UART transmitter:
//   - register offsets, decoded from addr[3:2]
//   - STATUS register bit positions
//   - shifter FSM state encoding
//   - eff_div(): maps the programmed divisor to clocks per bit (0 acts as 1)
// ----------------------------------------------------------------------------
package uart_tx_lite_pkg;

   // Register offsets (word index, addr[3:2])
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // STATUS bit positions
   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_COUNT_LSB = 8;

   // Shifter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // A programmed divisor of 0 would never let the baud counter expire
   // usefully, so it is run as 1 clock per bit.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO with show-ahead read data: o_data always presents the
// oldest entry, and i_pop retires it at the clock edge.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_data  write one byte (ignored when full)
//   i_pop,  o_data  retire the head entry (ignored when empty) / head entry
//   o_full, o_empty occupancy flags, derived from the registered count
//   o_count         number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [7:0]                 i_data,
   input  logic                       i_pop,
   output logic [7:0]                 o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // Storage is not reset: reset only clears the pointers and count,
   // which is enough to discard the contents.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_lite.sv
// ----------------------------------------------------------------------------
// uart_tx_lite
// Memory-mapped console UART transmitter. Byte writes to TXDATA are queued in
// a FIFO and sent as 8N1 frames on txd_o. Firmware polls STATUS and sets the
// bit period through DIV.
// Parameters:
//   FIFO_DEPTH  TX FIFO entries (power of two, 2..256)
//   DIV_RESET   reset value of the DIV register (clocks per bit)
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   mem_d_addr_i        byte address, only [3:2] decoded
//   mem_d_data_wr_i     write data
//   mem_d_rd_i          read request
//   mem_d_wr_i          byte write strobes (non-zero = write)
//   mem_d_req_tag_i     request tag
//   mem_d_accept_o      request accepted this cycle
//   mem_d_ack_o         response valid (one cycle after acceptance)
//   mem_d_error_o       response error, qualified by ack
//   mem_d_resp_tag_o    echoed tag, qualified by ack
//   mem_d_data_rd_o     read data, qualified by ack
//   txd_o               serial output, idle high
// Handshake: a request is taken in any cycle where (rd | |wr) & accept is
// high; its response (ack + error/tag/data) is presented for exactly the
// following cycle. Accept only drops for a TXDATA write while the FIFO is full.
// ----------------------------------------------------------------------------
module uart_tx_lite
   import uart_tx_lite_pkg::*;
#(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic [10:0] mem_d_req_tag_i,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [10:0] mem_d_resp_tag_o,
   output logic [31:0] mem_d_data_rd_o,
   output logic        txd_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // ---------------------------------------------------------------- decode
   logic          w_is_wr;
   logic          w_req;
   logic [1:0]    w_off;
   logic          w_txdata_wr;
   logic          w_take;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_status;
   logic [31:0]   w_rd_data;
   logic [7:0]    w_count8;

   logic [7:0]    w_fifo_data;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [CW-1:0] w_fifo_count;

   logic          w_baud_done;
   logic          w_unused_bits;

   // ------------------------------------------------------------- registers
   logic          r_ack;
   logic          r_err;
   logic [10:0]   r_tag;
   logic [31:0]   r_rdata;
   logic [15:0]   r_div;

   tx_state_e     r_state;
   logic          r_txd;
   logic [15:0]   r_baud_cnt;
   logic [15:0]   r_div_act;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;

   assign w_is_wr     = |mem_d_wr_i;
   assign w_req       = mem_d_rd_i | w_is_wr;
   assign w_off       = mem_d_addr_i[3:2];
   assign w_txdata_wr = w_is_wr && (w_off == REG_TXDATA);

   // Back-pressure uses the registered full flag, so a pop in the same cycle
   // does not open a slot for this push.
   assign mem_d_accept_o = ~(w_txdata_wr & w_fifo_full);
   assign w_take         = w_req & mem_d_accept_o;
   assign w_push         = w_take & w_txdata_wr & mem_d_wr_i[0];

   // Bits of the bus not used by this register map.
   assign w_unused_bits = ^{mem_d_addr_i[31:4], mem_d_addr_i[1:0],
                            mem_d_data_wr_i[31:16]};

   // ------------------------------------------------------------------ FIFO
   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_push),
      .i_data  (mem_d_data_wr_i[7:0]),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // --------------------------------------------------------- read datapath
   // The count field is 8 bits wide; only a 256-deep FIFO can exceed it, and
   // its full flag still reports that case.
   assign w_count8 = 8'(w_fifo_count);

   always_comb begin
      w_status                 = '0;
      w_status[STAT_FULL]      = w_fifo_full;
      w_status[STAT_EMPTY]     = w_fifo_empty;
      w_status[STAT_BUSY]      = (r_state != IDLE);
      w_status[STAT_COUNT_LSB +: 8] = w_count8;
   end

   always_comb begin
      w_rd_data = '0;
      case (w_off)
         REG_STATUS: w_rd_data = w_status;
         REG_DIV:    w_rd_data = {16'h0000, r_div};
         default:    w_rd_data = '0;
      endcase
   end

   // ------------------------------------------------------ response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_tag   <= '0;
         r_rdata <= '0;
      end else begin
         r_ack <= w_take;
         if (w_take) begin
            r_tag   <= mem_d_req_tag_i;
            r_err   <= (w_off == REG_RSVD);
            // A request with both rd and wr is a write; writes return 0.
            r_rdata <= w_is_wr ? 32'h0 : w_rd_data;
         end else begin
            r_err   <= 1'b0;
            r_rdata <= '0;
         end
      end
   end

   assign mem_d_ack_o      = r_ack;
   assign mem_d_error_o    = r_err;
   assign mem_d_resp_tag_o = r_tag;
   assign mem_d_data_rd_o  = r_rdata;

   // ------------------------------------------------------------ DIV register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_div <= DIV_RESET;
      end else if (w_take && w_is_wr && (w_off == REG_DIV)) begin
         if (mem_d_wr_i[0]) begin
            r_div[7:0] <= mem_d_data_wr_i[7:0];
         end
         if (mem_d_wr_i[1]) begin
            r_div[15:8] <= mem_d_data_wr_i[15:8];
         end
      end
   end

   // ----------------------------------------------------------------- shifter
   assign w_baud_done = (r_baud_cnt == 16'd0);

   // A new byte is taken from IDLE, or in the final STOP cycle so that
   // consecutive frames run with no idle gap.
   assign w_pop = ~w_fifo_empty &
                  ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

   // The divisor is latched at each start bit; a DIV write mid-frame only
   // changes the next frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_txd      <= 1'b1;
         r_baud_cnt <= '0;
         r_div_act  <= 16'd1;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_state    <= START;
                  r_txd      <= 1'b0;
                  r_shift    <= w_fifo_data;
                  r_div_act  <= eff_div(r_div);
                  r_baud_cnt <= eff_div(r_div) - 16'd1;
               end
            end

            START: begin
               if (w_baud_done) begin
                  r_state    <= DATA;
                  r_txd      <= r_shift[0];
                  r_shift    <= {1'b0, r_shift[7:1]};
                  r_bit_cnt  <= '0;
                  r_baud_cnt <= r_div_act - 16'd1;
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end

            DATA: begin
               if (w_baud_done) begin
                  r_baud_cnt <= r_div_act - 16'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_txd     <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end

            STOP: begin
               if (w_baud_done) begin
                  if (w_pop) begin
                     r_state    <= START;
                     r_txd      <= 1'b0;
                     r_shift    <= w_fifo_data;
                     r_div_act  <= eff_div(r_div);
                     r_baud_cnt <= eff_div(r_div) - 16'd1;
                  end else begin
                     r_state <= IDLE;
                     r_txd   <= 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 16'd1;
               end
            end

            default: begin
               r_state <= IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

   assign txd_o = r_txd;

endmodule

// File: tb/tb_uart_tx_lite.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_lite
// Bench for the console UART. A frame monitor holds the reference model: a
// queue of bytes accepted on TXDATA and the bit period in force, from which it
// builds the expected 10-bit 8N1 frame and compares every clock of it.
// ----------------------------------------------------------------------------
module tb_uart_tx_lite;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rd;
   logic [3:0]  wr;
   logic [10:0] tag;
   logic        accept;
   logic        ack;
   logic        err;
   logic [10:0] rtag;
   logic [31:0] rdata;
   logic        txd;

   uart_tx_lite #(
      .FIFO_DEPTH (16),
      .DIV_RESET  (16'd4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .mem_d_addr_i     (addr),
      .mem_d_data_wr_i  (wdata),
      .mem_d_rd_i       (rd),
      .mem_d_wr_i       (wr),
      .mem_d_req_tag_i  (tag),
      .mem_d_accept_o   (accept),
      .mem_d_ack_o      (ack),
      .mem_d_error_o    (err),
      .mem_d_resp_tag_o (rtag),
      .mem_d_data_rd_o  (rdata),
      .txd_o            (txd)
   );

   // ------------------------------------------------------------ clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- scoreboard
   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         m_div    = 4;
   bit         mon_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, obs, exp);
      end
   endtask

   // Expected frame: start 0, 8 data bits LSB first, stop 1, each held for
   // m_div clocks. Entered on the first low sample of a frame.
   task automatic run_frame();
      logic [9:0] frame;
      logic [7:0] eb;
      logic [7:0] ob;
      int         d;
      int         errs;
      bit         have;
      mon_busy = 1'b1;
      start_q.push_back(cyc);
      d    = m_div;
      have = (exp_q.size() > 0);
      eb   = have ? exp_q.pop_front() : 8'h00;
      if (!have) check("unexpected_frame", 32'd1, 32'd0);
      frame = {1'b1, eb, 1'b0};
      errs  = 0;
      ob    = '0;
      for (int i = 0; i < 10 * d; i++) begin
         if (i > 0) @(negedge clk);
         if (rst) begin
            mon_busy = 1'b0;
            return;
         end
         if (txd !== frame[i / d]) errs++;
         if ((i % d) == (d / 2) && (i / d) >= 1 && (i / d) <= 8)
            ob[(i / d) - 1] = txd;
      end
      if (have) begin
         check("frame_byte", {24'h0, ob}, {24'h0, eb});
         check("frame_shape", errs, 0);
      end
      mon_busy = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && txd === 1'b0) run_frame();
      end
   end

   // ---------------------------------------------------------------- drivers
   logic [31:0] got_data;
   logic        got_err;
   logic [10:0] got_tag;
   logic        got_ack;
   bit          got_blocked;
   int          got_cyc;

   // One request, held until accepted (bounded); response sampled the cycle
   // after acceptance.
   task automatic do_req(input logic i_rd, input logic [3:0] i_wr,
                         input logic [31:0] i_addr, input logic [31:0] i_data,
                         input logic [10:0] i_tag);
      int n;
      @(negedge clk);
      rd = i_rd; wr = i_wr; addr = i_addr; wdata = i_data; tag = i_tag;
      #1;
      got_blocked = (accept !== 1'b1);
      n = 0;
      while (accept !== 1'b1 && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      got_cyc = cyc;
      if (accept !== 1'b1) check("accept_timeout", 32'd0, 32'd1);
      else if (i_wr[0] && i_addr[3:2] == 2'd0) exp_q.push_back(i_data[7:0]);
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 4'h0;
      @(negedge clk);
      got_ack = ack; got_err = err; got_tag = rtag; got_data = rdata;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() > 0 || mon_busy || txd !== 1'b1) && n < 30000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", (n >= 30000), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic set_div(input logic [15:0] d);
      do_req(1'b0, 4'b0011, 32'h8, {16'h0, d}, 11'h0);
      m_div = (d == 16'd0) ? 1 : int'(d);
   endtask

   // ------------------------------------------------------------ main stimulus
   int         n_low;
   logic [7:0] b;
   logic [15:0] d;

   initial begin
      rd = 1'b0; wr = 4'h0; addr = '0; wdata = '0; tag = '0; rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_accept", accept, 1);
      check("rst_ack",    ack,    0);
      check("rst_err",    err,    0);
      check("rst_tag",    rtag,   0);
      check("rst_data",   rdata,  0);
      check("rst_txd",    txd,    1);
      rst = 1'b0;

      // Status and DIV after reset
      do_req(1'b1, 4'h0, 32'h4, 32'h0, 11'h001);
      check("stat_rst", got_data, 32'h2);
      check("stat_rst_ack", got_ack, 1);
      check("stat_rst_tag", got_tag, 11'h001);
      do_req(1'b1, 4'h0, 32'h8, 32'h0, 11'h002);
      check("div_rst", got_data, 32'd4);

      // 0x41 at DIV=4: txd still high in N+1, low in N+2
      do_req(1'b0, 4'b0001, 32'h0, 32'h41, 11'h003);
      check("t1_ack", got_ack, 1);
      check("t1_err", got_err, 0);
      check("t1_txd_n1", txd, 1);
      @(negedge clk);
      check("t1_txd_n2", txd, 0);
      wait_drain();

      // DIV byte strobes: only the upper byte lane written
      do_req(1'b0, 4'b0010, 32'h8, 32'h0000_0700, 11'h004);
      do_req(1'b1, 4'h0, 32'h8, 32'h0, 11'h005);
      check("div_lane1", got_data, 32'h0704);
      set_div(16'd4);

      // TXDATA write without wr[0]: acked, nothing queued
      do_req(1'b0, 4'b0010, 32'h0, 32'h0000_5555, 11'h006);
      check("nolane_ack", got_ack, 1);
      check("nolane_err", got_err, 0);
      do_req(1'b1, 4'h0, 32'h4, 32'h0, 11'h007);
      check("nolane_stat", got_data, 32'h2);

      // STATUS write ignored, no error
      do_req(1'b0, 4'hF, 32'h4, 32'hFFFF_FFFF, 11'h008);
      check("statwr_err", got_err, 0);
      do_req(1'b1, 4'h0, 32'h8, 32'h0, 11'h009);
      check("statwr_div", got_data, 32'd4);

      // Reserved offset
      do_req(1'b1, 4'h0, 32'hC, 32'h0, 11'h5A5);
      check("rsvd_ack",  got_ack,  1);
      check("rsvd_err",  got_err,  1);
      check("rsvd_tag",  got_tag,  11'h5A5);
      check("rsvd_data", got_data, 0);
      do_req(1'b0, 4'hF, 32'hC, 32'h1234, 11'h011);
      check("rsvd_wr_err", got_err, 1);

      // Back-to-back reads give back-to-back acks
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check("b2b_ack", ack, 1);
            check("b2b_tag", rtag, 32'(16 + k - 1));
         end
         if (k < 3) begin
            rd = 1'b1; addr = 32'h4; tag = 11'(16 + k);
         end else begin
            rd = 1'b0;
         end
      end
      @(negedge clk);
      check("ack_single", ack, 0);

      // DIV=0 runs 1 clock per bit; readback keeps 0
      set_div(16'd0);
      do_req(1'b1, 4'h0, 32'h8, 32'h0, 11'h012);
      check("div0_rb", got_data, 0);
      do_req(1'b0, 4'b0001, 32'h0, 32'hFF, 11'h013);
      wait_drain();

      // Random bytes at random bit periods with random gaps
      for (int r = 0; r < 5; r++) begin
         d = 16'($urandom_range(0, 5));
         set_div(d);
         do_req(1'b1, 4'h0, 32'h8, 32'h0, 11'h014);
         check("rnd_div_rb", got_data, {16'h0, d});
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            b = 8'($urandom_range(0, 255));
            do_req(1'b0, 4'b0001, 32'h0, {24'h0, b}, 11'($urandom_range(0, 2047)));
            check("rnd_wr_err", got_err, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         wait_drain();
      end

      // STATUS while busy: one byte in the shifter, two queued
      set_div(16'd50);
      for (int j = 0; j < 3; j++)
         do_req(1'b0, 4'b0001, 32'h0, 32'h30 + j, 11'h020);
      do_req(1'b1, 4'h0, 32'h4, 32'h0, 11'h021);
      check("stat_busy", got_data, 32'h0000_0204);
      wait_drain();

      // Back-pressure: 17 writes fill 1 + 16, the 18th waits for frame 1 end
      set_div(16'd100);
      start_q.delete();
      for (int j = 0; j < 17; j++) begin
         do_req(1'b0, 4'b0001, 32'h0, 32'($urandom_range(0, 255)), 11'h030);
         if (j == 16) check("bp_w17_blocked", got_blocked, 0);
      end
      do_req(1'b1, 4'h0, 32'h4, 32'h0, 11'h031);
      check("stat_full", got_data, 32'h0000_1005);
      do_req(1'b0, 4'b0001, 32'h0, 32'hC3, 11'h032);
      check("bp_w18_blocked", got_blocked, 1);
      if (start_q.size() > 0)
         check("bp_accept_cycle", got_cyc, start_q[0] + 10 * 100);
      else
         check("bp_first_start", 32'd0, 32'd1);
      wait_drain();

      // Reset in the DATA phase of a 0x00 frame, two more bytes queued
      set_div(16'd8);
      do_req(1'b0, 4'b0001, 32'h0, 32'h00, 11'h040);
      do_req(1'b0, 4'b0001, 32'h0, 32'h5A, 11'h041);
      do_req(1'b0, 4'b0001, 32'h0, 32'h3C, 11'h042);
      repeat (20) @(negedge clk);
      check("pre_rst_txd", txd, 0);
      #2 rst = 1'b1;
      #1 check("rst_txd_async", txd, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_div = 4;
      do_req(1'b1, 4'h0, 32'h4, 32'h0, 11'h043);
      check("post_rst_stat", got_data, 32'h2);
      do_req(1'b1, 4'h0, 32'h8, 32'h0, 11'h044);
      check("post_rst_div", got_data, 32'd4);
      n_low = 0;
      repeat (300) begin
         @(negedge clk);
         if (txd !== 1'b1) n_low++;
      end
      check("post_rst_quiet", n_low, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_lite.md
# uart_tx_lite

Memory-mapped UART transmitter on the core's data-memory port, decoding the console window the core writes characters to (base 0x9200_0000). Accepts byte writes through the same request/accept/ack/tag protocol the TCM uses on its data side, buffers them in a small FIFO and serialises them as 8N1 frames on `txd_o`. Provides a status register so firmware can poll, and it drops into the core-plus-TCM test harness as the real console sink.

## Interface
- `FIFO_DEPTH`, 16: TX FIFO entries, power of two, 2..256.
- `DIV_RESET`, 16'd4: reset value of the bit-period divisor, in clocks per bit.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mem_d_addr_i` in 32: byte address. Only `[3:2]` is decoded; the enclosing fabric does window select.
- `mem_d_data_wr_i` in 32: write data.
- `mem_d_rd_i` in 1: read request.
- `mem_d_wr_i` in 4: byte write strobes. Non-zero means a write.
- `mem_d_req_tag_i` in 11: request tag.
- `mem_d_accept_o` out 1: request accepted this cycle.
- `mem_d_ack_o` out 1: response valid.
- `mem_d_error_o` out 1: response error, qualified by ack.
- `mem_d_resp_tag_o` out 11: echoed request tag.
- `mem_d_data_rd_o` out 32: read data, qualified by ack.
- `txd_o` out 1: serial output, idle high.

## Operation
- A request is taken when `(mem_d_rd_i | |mem_d_wr_i) & mem_d_accept_o`.
- Register map, by `addr[3:2]`:
  - 0 TXDATA (W): pushes `data_wr[7:0]`. Requires `wr[0]`; a write with `wr[0]`=0 is a no-op but is still acked without error. Reads return 0.
  - 1 STATUS (R): bit0 full, bit1 empty, bit2 busy (shifter active), bits[15:8] FIFO count. Writes are ignored.
  - 2 DIV (R/W): bits[15:0] set clocks per bit. A write uses `wr[1:0]`. A value of 0 is treated as 1. The new value takes effect at the next start bit.
  - 3: the request is acked with `error_o`=1 and read data 0.
- A request carrying both rd and wr is treated as a write.
- `accept_o` = 0 only when the request is a TXDATA write while the FIFO is full. The decision uses the registered count, so a pop in the same cycle does not allow the push.
- In every other case `accept_o` = 1, including when no request is present.
- Shifter FSM:
  - IDLE: `txd`=1. If the FIFO is not empty, pop and go to START.
  - START: `txd`=0 for 1 bit period.
  - DATA: 8 bit periods, LSB first.
  - STOP: `txd`=1 for 1 bit period, then return to IDLE.
- busy = state≠IDLE.
- Push and pop in the same cycle leave count unchanged. Read/write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Response latency is 1 cycle. `ack_o`, `error_o`, `resp_tag_o` and `data_rd_o` are registered and valid for exactly one cycle after acceptance. Back-to-back requests give back-to-back acks.
- STATUS is sampled at acceptance. A push accepted in cycle N is visible in a STATUS read accepted in N+1.
- A pushed byte reaches the FIFO at the clock edge ending cycle N. If IDLE and the FIFO was empty, the pop occurs in N+1 and `txd_o` falls in N+2.
- Frame length is 10×DIV clocks. Back-to-back frames have no idle gap: the next pop occurs in the last STOP cycle.
- Reset values:
  - `accept_o`=1, `ack_o`=0, `error_o`=0, `resp_tag_o`=0, `data_rd_o`=0.
  - `txd_o`=1.
  - FIFO empty, state IDLE, DIV=`DIV_RESET`.
- Reset mid-frame aborts the frame; `txd_o` goes high asynchronously and the FIFO contents are discarded.

## Structure
- Shared package `uart_tx_lite_pkg`:
  - register offset constants.
  - STATUS bit positions.
  - FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module `uart_tx_fifo`: synchronous FIFO.
  - Parameter: DEPTH.
  - Ports: push/data_in, pop/data_out, full, empty, count.
- Top level holds:
  - bus decode.
  - response registers.
  - DIV register.
  - baud counter.
  - bit counter.
  - shift register.

## Test plan
- Reset, then write TXDATA=0x41 with DIV=4 -> ack next cycle with no error. `txd_o` low from cycle N+2 for 4 clocks, then bits 1,0,0,0,0,0,1,0 at 4 clocks each, then high for 4 clocks.
- 17 writes back-to-back with DEPTH=16 and the shifter blocked by DIV=0xFFFF -> the first write pops immediately. The 17th write is accepted, the 18th sees `accept_o`=0 until the first frame ends, then is accepted.
- Read STATUS after reset -> `data_rd_o`=0x0000_0002. After two queued writes while busy -> count=1 or 2 as the pop timing dictates, and busy=1.
- Write DIV=0 then TXDATA=0xFF -> 1 clock per bit, 10-clock frame. Read DIV returns 0.
- Access offset 0xC with tag 0x5A5 -> ack with `error_o`=1 and `resp_tag_o`=0x5A5.
- Assert `rst_i` in the middle of the DATA phase -> `txd_o`=1 asynchronously. After release, STATUS reads 0x0000_0002 and no residual frame is sent.
